rgb_maxmin_pipe: RTL and testbench

//  Streaming front end for skin-colour segmentation.

---
 rtl/rgb_maxmin_pipe_if.sv | 29 ++
 rtl/rgb_maxmin_pipe.sv | 156 +++++++++++++++
 tb/tb_rgb_maxmin_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_maxmin_pipe_if.sv
// Pixel stream in, per-pixel max/min/delta stream out; valid/ready on both sides.
interface rgb_maxmin_pipe_if #(parameter int W = 10);
   logic         s_valid;
   logic         s_ready;
   logic [W-1:0] s_r;
   logic [W-1:0] s_g;
   logic [W-1:0] s_b;
   logic         s_sof;
   logic         s_eof;
   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] m_max;
   logic [W-1:0] m_min;
   logic [W-1:0] m_delta;
   logic [1:0]   m_idx;
   logic         m_gray;
   logic         m_sof;
   logic         m_eof;

   modport slave (
      input  s_valid, s_r, s_g, s_b, s_sof, s_eof, m_ready,
      output s_ready, m_valid, m_max, m_min, m_delta, m_idx, m_gray, m_sof, m_eof
   );

   modport master (
      output s_valid, s_r, s_g, s_b, s_sof, s_eof, m_ready,
      input  s_ready, m_valid, m_max, m_min, m_delta, m_idx, m_gray, m_sof, m_eof
   );
endinterface

// File: rtl/rgb_maxmin_pipe.sv
// Two-stage RGB max/min/delta pipeline with per-frame dominant-channel histograms.
module rgb_maxmin_pipe #(
   parameter int W     = 10,
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   rgb_maxmin_pipe_if.slave pix,
   output logic             st_valid,
   output logic [CNT_W-1:0] st_cnt_r,
   output logic [CNT_W-1:0] st_cnt_g,
   output logic [CNT_W-1:0] st_cnt_b,
   output logic             st_sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic         v1_q, v2_q;
   logic         ld1, ld2, m_xfer;
   logic [W-1:0] max1_d, min1_d;
   logic [1:0]   idx1_d;
   logic [W-1:0] max1_q, min1_q;
   logic [1:0]   idx1_q;
   logic         sof1_q, eof1_q;
   logic [W-1:0] max2_q, min2_q, delta2_q;
   logic [1:0]   idx2_q;
   logic         gray2_q, sof2_q, eof2_q;

   logic [CNT_W-1:0] cnt_d [3];
   logic [CNT_W-1:0] cnt_q [3];
   logic             sat_d, sat_q;
   logic [CNT_W-1:0] st_cnt_r_q, st_cnt_g_q, st_cnt_b_q;
   logic             st_sat_q, st_valid_q;

   // A stage may load when it is empty or the stage after it is moving.
   assign ld2         = !v2_q | pix.m_ready;
   assign ld1         = !v1_q | ld2;
   assign pix.s_ready = rst_n & ld1;
   assign m_xfer      = v2_q & pix.m_ready;

   always_comb begin
      max1_d = pix.s_r;
      min1_d = pix.s_r;
      idx1_d = 2'd2;
      if (pix.s_g > max1_d) max1_d = pix.s_g;
      if (pix.s_b > max1_d) max1_d = pix.s_b;
      if (pix.s_g < min1_d) min1_d = pix.s_g;
      if (pix.s_b < min1_d) min1_d = pix.s_b;
      if (pix.s_r > pix.s_g && pix.s_r > pix.s_b) begin
         idx1_d = 2'd0;
      end else if (pix.s_g > pix.s_r && pix.s_g > pix.s_b) begin
         idx1_d = 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q     <= 1'b0;
         max1_q   <= '0;
         min1_q   <= '0;
         idx1_q   <= '0;
         sof1_q   <= 1'b0;
         eof1_q   <= 1'b0;
         v2_q     <= 1'b0;
         max2_q   <= '0;
         min2_q   <= '0;
         delta2_q <= '0;
         idx2_q   <= '0;
         gray2_q  <= 1'b0;
         sof2_q   <= 1'b0;
         eof2_q   <= 1'b0;
      end else begin
         if (ld1) begin
            v1_q <= pix.s_valid;
            if (pix.s_valid) begin
               max1_q <= max1_d;
               min1_q <= min1_d;
               idx1_q <= idx1_d;
               sof1_q <= pix.s_sof;
               eof1_q <= pix.s_eof;
            end
         end
         if (ld2) begin
            v2_q <= v1_q;
            if (v1_q) begin
               max2_q   <= max1_q;
               min2_q   <= min1_q;
               delta2_q <= max1_q - min1_q;
               idx2_q   <= idx1_q;
               gray2_q  <= (max1_q == min1_q);
               sof2_q   <= sof1_q;
               eof2_q   <= eof1_q;
            end
         end
      end
   end

   assign pix.m_valid = v2_q;
   assign pix.m_max   = max2_q;
   assign pix.m_min   = min2_q;
   assign pix.m_delta = delta2_q;
   assign pix.m_idx   = idx2_q;
   assign pix.m_gray  = gray2_q;
   assign pix.m_sof   = sof2_q;
   assign pix.m_eof   = eof2_q;

   // Histogram counts what actually leaves the block, so stalls never double-count.
   always_comb begin
      for (int c = 0; c < 3; c++) cnt_d[c] = cnt_q[c];
      sat_d = sat_q;
      if (m_xfer) begin
         if (sof2_q) begin
            for (int c = 0; c < 3; c++) begin
               cnt_d[c] = (idx2_q == 2'(c)) ? CNT_W'(1) : '0;
            end
            sat_d = 1'b0;
         end else begin
            for (int c = 0; c < 3; c++) begin
               if (idx2_q == 2'(c)) begin
                  if (cnt_q[c] == CNT_MAX) sat_d = 1'b1;
                  else cnt_d[c] = cnt_q[c] + CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < 3; c++) cnt_q[c] <= '0;
         sat_q      <= 1'b0;
         st_valid_q <= 1'b0;
         st_cnt_r_q <= '0;
         st_cnt_g_q <= '0;
         st_cnt_b_q <= '0;
         st_sat_q   <= 1'b0;
      end else begin
         for (int c = 0; c < 3; c++) cnt_q[c] <= cnt_d[c];
         sat_q      <= sat_d;
         st_valid_q <= m_xfer & eof2_q;
         if (m_xfer & eof2_q) begin
            st_cnt_r_q <= cnt_d[0];
            st_cnt_g_q <= cnt_d[1];
            st_cnt_b_q <= cnt_d[2];
            st_sat_q   <= sat_d;
         end
      end
   end

   assign st_valid = st_valid_q;
   assign st_cnt_r = st_cnt_r_q;
   assign st_cnt_g = st_cnt_g_q;
   assign st_cnt_b = st_cnt_b_q;
   assign st_sat   = st_sat_q;

endmodule

// File: tb/tb_rgb_maxmin_pipe.sv
// Drives one stimulus stream into a wide-counter and a 3-bit-counter instance; checks both against a model.
module tb_rgb_maxmin_pipe;
   localparam int W = 10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rgb_maxmin_pipe_if #(.W(W)) ifa ();
   rgb_maxmin_pipe_if #(.W(W)) ifb ();

   logic        sta_valid, sta_sat, stb_valid, stb_sat;
   logic [19:0] sta_r, sta_g, sta_b;
   logic [2:0]  stb_r, stb_g, stb_b;

   logic rdy_mode, mr_man, mr_rand;
   int   rdy_pct = 70;

   assign ifa.m_ready = rdy_mode ? mr_man : mr_rand;
   assign ifb.s_valid = ifa.s_valid;
   assign ifb.s_r     = ifa.s_r;
   assign ifb.s_g     = ifa.s_g;
   assign ifb.s_b     = ifa.s_b;
   assign ifb.s_sof   = ifa.s_sof;
   assign ifb.s_eof   = ifa.s_eof;
   assign ifb.m_ready = ifa.m_ready;

   rgb_maxmin_pipe #(.W(W), .CNT_W(20)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .pix(ifa), .st_valid(sta_valid),
      .st_cnt_r(sta_r), .st_cnt_g(sta_g), .st_cnt_b(sta_b), .st_sat(sta_sat));

   rgb_maxmin_pipe #(.W(W), .CNT_W(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .pix(ifb), .st_valid(stb_valid),
      .st_cnt_r(stb_r), .st_cnt_g(stb_g), .st_cnt_b(stb_b), .st_sat(stb_sat));

   typedef struct {
      int mx; int mn; int dl; int idx; bit gray; bit sof; bit eof;
   } pix_t;

   pix_t expq[$];
   pix_t got[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pulses = 0;
   bit   pend = 1'b0;
   int   cnt  [2][3];
   int   ecnt [2][3];
   bit   sat  [2];
   bit   esat [2];
   int   lim  [2] = '{(1 << 20) - 1, 7};
   bit   prev_stall = 1'b0;
   logic [35:0] held_a, held_b;
   pix_t e, g;

   wire [35:0] pk_a = {ifa.m_valid, ifa.m_max, ifa.m_min, ifa.m_delta, ifa.m_idx,
                       ifa.m_gray, ifa.m_sof, ifa.m_eof};
   wire [35:0] pk_b = {ifb.m_valid, ifb.m_max, ifb.m_min, ifb.m_delta, ifb.m_idx,
                       ifb.m_gray, ifb.m_sof, ifb.m_eof};

   function automatic pix_t model(int r, int gg, int b, bit sof, bit eof);
      pix_t p;
      p.mx = r;
      if (gg > p.mx) p.mx = gg;
      if (b > p.mx) p.mx = b;
      p.mn = r;
      if (gg < p.mn) p.mn = gg;
      if (b < p.mn) p.mn = b;
      p.dl   = p.mx - p.mn;
      p.gray = (p.dl == 0);
      if (r > gg && r > b) p.idx = 0;
      else if (gg > r && gg > b) p.idx = 1;
      else p.idx = 2;
      p.sof = sof;
      p.eof = eof;
      return p;
   endfunction

   function automatic logic [35:0] pack_e(pix_t p);
      return {1'b1, 10'(p.mx), 10'(p.mn), 10'(p.dl), 2'(p.idx), p.gray, p.sof, p.eof};
   endfunction

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      mr_rand = ($urandom_range(99) < rdy_pct);
   end

   // Scoreboard and frame-stat model, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         expq.delete();
         for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) cnt[k][c] = 0;
            sat[k] = 1'b0;
         end
         pend       = 1'b0;
         prev_stall = 1'b0;
      end else begin
         check("st_valid_a", 64'(sta_valid), 64'(pend));
         check("st_valid_b", 64'(stb_valid), 64'(pend));
         if (pend) begin
            pulses++;
            check("st_cnt_r_a", 64'(sta_r), 64'(ecnt[0][0]));
            check("st_cnt_g_a", 64'(sta_g), 64'(ecnt[0][1]));
            check("st_cnt_b_a", 64'(sta_b), 64'(ecnt[0][2]));
            check("st_sat_a",   64'(sta_sat), 64'(esat[0]));
            check("st_cnt_r_b", 64'(stb_r), 64'(ecnt[1][0]));
            check("st_cnt_g_b", 64'(stb_g), 64'(ecnt[1][1]));
            check("st_cnt_b_b", 64'(stb_b), 64'(ecnt[1][2]));
            check("st_sat_b",   64'(stb_sat), 64'(esat[1]));
         end
         pend = 1'b0;
         if (prev_stall) begin
            check("hold_a", 64'(pk_a), 64'(held_a));
            check("hold_b", 64'(pk_b), 64'(held_b));
         end
         if (ifa.m_valid === 1'b1 && ifa.m_ready === 1'b1) begin
            if (expq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got %h, expected no output", pk_a);
            end else begin
               e = expq.pop_front();
               check("pixel_a", 64'(pk_a), 64'(pack_e(e)));
               check("pixel_b", 64'(pk_b), 64'(pack_e(e)));
               g.mx = int'(ifa.m_max);  g.mn = int'(ifa.m_min); g.dl = int'(ifa.m_delta);
               g.idx = int'(ifa.m_idx); g.gray = ifa.m_gray;
               g.sof = ifa.m_sof;       g.eof = ifa.m_eof;
               got.push_back(g);
               for (int k = 0; k < 2; k++) begin
                  if (e.sof) begin
                     for (int c = 0; c < 3; c++) cnt[k][c] = 0;
                     cnt[k][e.idx] = 1;
                     sat[k] = 1'b0;
                  end else if (cnt[k][e.idx] == lim[k]) begin
                     sat[k] = 1'b1;
                  end else begin
                     cnt[k][e.idx]++;
                  end
                  if (e.eof) begin
                     for (int c = 0; c < 3; c++) ecnt[k][c] = cnt[k][c];
                     esat[k] = sat[k];
                  end
               end
               pend = e.eof;
            end
         end
         prev_stall = (ifa.m_valid === 1'b1) && (ifa.m_ready !== 1'b1);
         held_a = pk_a;
         held_b = pk_b;
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(int r, int gg, int b, bit sof, bit eof);
      int  n;
      bit  ok;
      n  = 0;
      ok = 1'b0;
      ifa.s_valid = 1'b1;
      ifa.s_r = W'(r);
      ifa.s_g = W'(gg);
      ifa.s_b = W'(b);
      ifa.s_sof = sof;
      ifa.s_eof = eof;
      do begin
         @(negedge clk);
         ok = (ifa.s_ready === 1'b1);
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 1000);
      ifa.s_valid = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: got s_ready=0 for %0d cycles, expected 1", n);
      end else begin
         expq.push_back(model(r, gg, b, sof, eof));
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      rdy_mode = 1'b1;
      mr_man   = 1'b1;
      while (expq.size() != 0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("drain_empty", 64'(expq.size()), 64'd0);
   endtask

   function automatic int rcol();
      int v;
      if ($urandom_range(3) != 0) return int'($urandom_range(1023));
      v = int'($urandom_range(2));
      return (v == 0) ? 0 : ((v == 1) ? 512 : 1023);
   endfunction

   initial begin
      int p0, gb, len;
      bit abort, saw_nr;
      rst_n = 1'b0;
      rdy_mode = 1'b1;
      mr_man = 1'b1;
      ifa.s_valid = 1'b0;
      ifa.s_r = '0; ifa.s_g = '0; ifa.s_b = '0;
      ifa.s_sof = 1'b0; ifa.s_eof = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_m_valid",  64'(ifa.m_valid), 64'd0);
      check("rst_st_valid", 64'(sta_valid), 64'd0);
      check("rst_st_cnt_r", 64'(sta_r), 64'd0);
      check("rst_st_cnt_g", 64'(sta_g), 64'd0);
      check("rst_st_cnt_b", 64'(sta_b), 64'd0);
      check("rst_s_ready",  64'(ifa.s_ready), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_s_ready", 64'(ifa.s_ready), 64'd1);
      @(posedge clk);
      #1;

      // Pixels before any sof still count; the eof on the fourth reports 1/0/3.
      send(700, 200, 100, 1'b0, 1'b0);
      send(500, 500, 100, 1'b0, 1'b0);
      send(300, 300, 300, 1'b0, 1'b0);
      send(0, 1023, 1023, 1'b0, 1'b1);
      drain();
      check("basic_max",   64'(got[0].mx), 64'd700);
      check("basic_min",   64'(got[0].mn), 64'd100);
      check("basic_delta", 64'(got[0].dl), 64'd600);
      check("basic_idx",   64'(got[0].idx), 64'd0);
      check("basic_gray",  64'(got[0].gray), 64'd0);
      check("tie2_idx",    64'(got[1].idx), 64'd2);
      check("tie2_max",    64'(got[1].mx), 64'd500);
      check("tie3_idx",    64'(got[2].idx), 64'd2);
      check("tie3_delta",  64'(got[2].dl), 64'd0);
      check("tie3_gray",   64'(got[2].gray), 64'd1);
      check("tiegb_idx",   64'(got[3].idx), 64'd2);
      check("presof_r", 64'(sta_r), 64'd1);
      check("presof_g", 64'(sta_g), 64'd0);
      check("presof_b", 64'(sta_b), 64'd3);

      // Backpressure: m_ready low in cycles 3..6 while streaming 8 pixels.
      gb = got.size();
      saw_nr = 1'b0;
      fork
         for (int i = 0; i < 8; i++) send(100 * i + 50, 40 * i, 1000 - 90 * i, 1'b0, 1'b0);
         for (int c = 0; c < 12; c++) begin
            mr_man = !(c >= 3 && c <= 6);
            @(negedge clk);
            if (ifa.s_ready !== 1'b1) saw_nr = 1'b1;
            @(posedge clk);
            #1;
         end
      join
      drain();
      check("bp_sready_fell", 64'(saw_nr), 64'd1);
      check("bp_count", 64'(got.size() - gb), 64'd8);

      // 10-pixel frame 5R/3G/2B, then a single-pixel G frame.
      p0 = pulses;
      send(600, 100, 100, 1'b1, 1'b0);
      send(100, 600, 100, 1'b0, 1'b0);
      send(700, 10, 20,   1'b0, 1'b0);
      send(10, 20, 900,   1'b0, 1'b0);
      send(800, 799, 0,   1'b0, 1'b0);
      send(5, 6, 4,       1'b0, 1'b0);
      send(1023, 0, 0,    1'b0, 1'b0);
      send(0, 300, 299,   1'b0, 1'b0);
      send(2, 3, 4,       1'b0, 1'b0);
      send(9, 8, 7,       1'b0, 1'b1);
      drain();
      check("frame_pulses", 64'(pulses - p0), 64'd1);
      check("frame_r",   64'(sta_r), 64'd5);
      check("frame_g",   64'(sta_g), 64'd3);
      check("frame_b",   64'(sta_b), 64'd2);
      check("frame_sat", 64'(sta_sat), 64'd0);
      send(10, 20, 5, 1'b1, 1'b1);
      drain();
      check("single_r", 64'(sta_r), 64'd0);
      check("single_g", 64'(sta_g), 64'd1);
      check("single_b", 64'(sta_b), 64'd0);

      // Aborted frame then a complete 2-pixel B frame: exactly one report.
      p0 = pulses;
      send(600, 1, 1, 1'b1, 1'b0);
      send(600, 1, 1, 1'b0, 1'b0);
      send(600, 1, 1, 1'b0, 1'b0);
      send(1, 1, 600, 1'b1, 1'b0);
      send(1, 2, 600, 1'b0, 1'b1);
      drain();
      check("abort_pulses", 64'(pulses - p0), 64'd1);
      check("abort_r", 64'(sta_r), 64'd0);
      check("abort_b", 64'(sta_b), 64'd2);

      // Nine R pixels: wide counter reads 9, 3-bit counter pins at 7 and flags.
      for (int i = 0; i < 9; i++) send(900, 10, 10, i == 0, i == 8);
      drain();
      check("sat_b_r",   64'(stb_r), 64'd7);
      check("sat_b_sat", 64'(stb_sat), 64'd1);
      check("sat_a_r",   64'(sta_r), 64'd9);
      check("sat_a_sat", 64'(sta_sat), 64'd0);

      // Random frames with random gaps and random downstream stalls.
      rdy_mode = 1'b0;
      for (int f = 0; f < 40; f++) begin
         len   = int'($urandom_range(12, 1));
         abort = ($urandom_range(9) == 0);
         for (int i = 0; i < len; i++) begin
            send(rcol(), rcol(), rcol(), i == 0, (i == len - 1) && !abort);
            if ($urandom_range(3) == 0) begin
               repeat (int'($urandom_range(3, 1))) @(posedge clk);
               #1;
            end
         end
      end
      drain();

      // Reset with pixels in flight discards them and the partial counts.
      mr_man = 1'b0;
      send(600, 100, 100, 1'b1, 1'b0);
      send(100, 600, 100, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midrst_m_valid",  64'(ifa.m_valid), 64'd0);
      check("midrst_s_ready",  64'(ifa.s_ready), 64'd0);
      check("midrst_st_cnt_g", 64'(sta_g), 64'd0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mr_man = 1'b1;
      send(900, 1, 2, 1'b0, 1'b1);
      drain();
      check("midrst_after_r", 64'(sta_r), 64'd1);
      check("midrst_after_g", 64'(sta_g), 64'd0);
      check("midrst_after_b", 64'(sta_b), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
